// File: rtl/key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_ctrl_pkg
// Description : Register map and debounce state encoding shared by the key
//               event controller and its per-key debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package key_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RELCAP  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_PRSCAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_REL        = 2'd0,
        ST_WAIT_PRESS = 2'd1,
        ST_PRS        = 2'd2,
        ST_WAIT_REL   = 2'd3
    } key_state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : One push-button: 2-FF synchronizer, polarity fix-up and a
//               four-state debounce FSM emitting single-cycle press/release events.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES  = 500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_db,
    output logic o_press_evt,
    output logic o_rel_evt
);

    localparam int              CNT_W       = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);
    localparam logic             c_rel_lvl  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_pressed;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= c_rel_lvl;
            r_sync2 <= c_rel_lvl;
            r_state <= ST_REL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_pressed = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // The counter only advances below its terminal value, so it cannot wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_press_evt = 1'b0;
        o_rel_evt   = 1'b0;
        case (r_state)
            ST_REL: begin
                if (w_pressed) begin
                    w_state_nxt = ST_WAIT_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_PRS;
                    w_cnt_nxt   = '0;
                    o_press_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_PRS: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_WAIT_REL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_REL: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_REL;
                    w_cnt_nxt   = '0;
                    o_rel_evt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_db = (r_state == ST_PRS) || (r_state == ST_WAIT_REL);

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_event_ctrl
// Description : Avalon-MM slave with NKEYS debounced push-buttons, W1C
//               press/release capture registers and a masked level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int NKEYS      = 4,
    parameter int DB_CYCLES  = 500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [NKEYS-1:0] in_port,
    output logic             irq
);

    logic [NKEYS-1:0] w_db;
    logic [NKEYS-1:0] w_press_evt;
    logic [NKEYS-1:0] w_rel_evt;
    logic [NKEYS-1:0] w_prs_clr;
    logic [NKEYS-1:0] w_rel_clr;
    logic [NKEYS-1:0] r_prscap;
    logic [NKEYS-1:0] r_relcap;
    logic [NKEYS-1:0] r_irqmask;
    logic [31:0]      w_rd_data;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic             w_wr;
    logic             w_unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            key_debounce #(
                .DB_CYCLES  (DB_CYCLES),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_key_debounce (
                .clk         (clk),
                .reset_n     (reset_n),
                .i_pin       (in_port[gi]),
                .o_db        (w_db[gi]),
                .o_press_evt (w_press_evt[gi]),
                .o_rel_evt   (w_rel_evt[gi])
            );
        end
    endgenerate

    assign w_wr           = chipselect & ~write_n;
    assign w_prs_clr      = (w_wr && address == ADDR_PRSCAP) ? writedata[NKEYS-1:0] : '0;
    assign w_rel_clr      = (w_wr && address == ADDR_RELCAP) ? writedata[NKEYS-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_rd_data = '0;
        case (address)
            ADDR_DATA:    w_rd_data[NKEYS-1:0] = w_db;
            ADDR_RELCAP:  w_rd_data[NKEYS-1:0] = r_relcap;
            ADDR_IRQMASK: w_rd_data[NKEYS-1:0] = r_irqmask;
            ADDR_PRSCAP:  w_rd_data[NKEYS-1:0] = r_prscap;
            default:      w_rd_data = '0;
        endcase
    end

    // OR-ing the event after the clear makes a same-cycle event win over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prscap   <= '0;
            r_relcap   <= '0;
            r_irqmask  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prscap   <= (r_prscap & ~w_prs_clr) | w_press_evt;
            r_relcap   <= (r_relcap & ~w_rel_clr) | w_rel_evt;
            if (w_wr && address == ADDR_IRQMASK) begin
                r_irqmask <= writedata[NKEYS-1:0];
            end
            r_readdata <= w_rd_data;
            r_irq      <= |((r_prscap | r_relcap) & r_irqmask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire
